reg_file_ctrl: RTL and testbench
================================

Name: reg_file_ctrl

Overview:
- Initiator/driver for the 8-entry x 8-bit `reg_file` control interface. It generates `SETSRC`, `SETDEST`, `REGWRITE`, `rt_index` and `write_value`, and consumes `rs` and `rt`.
- It turns single-beat register commands (write, read, copy, set-source) into correctly ordered multi-cycle strobe sequences.
- It sits between the instruction decoder/bench and `reg_file`.
- `reg_file` contract:
  - `SETSRC` latches `rt_index` as the source pointer on posedge `CLK`.
  - `SETDEST` latches `rt_index` as the destination pointer on posedge `CLK`.
  - `REGWRITE` writes `write_value` to `reg[dest]` on posedge `CLK`.
  - `rt` = `reg[rt_index]` combinationally; `rs` = `reg[src]`.

Parameters:
- DW, 8, data width of `write_value`/`rs`/`rt`/`req_data`/`rsp_data`
- AW, 3, register index width

Ports:
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- req_valid  in  1  command offered
- req_ready  out  1  controller can accept command
- req_op  in  2  00 WRITE, 01 READ, 10 COPY, 11 SETSRC
- req_src  in  AW  source register index (READ/COPY/SETSRC)
- req_dst  in  AW  destination register index (WRITE/COPY)
- req_data  in  DW  write data (WRITE only)
- rsp_valid  out  1  command complete, result valid
- rsp_ready  in  1  result consumed
- rsp_data  out  DW  result data
- SETSRC  out  1  to reg_file
- SETDEST  out  1  to reg_file
- REGWRITE  out  1  to reg_file
- rt_index  out  AW  to reg_file
- write_value  out  DW  to reg_file
- rs  in  DW  from reg_file
- rt  in  DW  from reg_file

Behaviour:
- Reset (RST_N=0, async):
  - state=IDLE.
  - All strobes 0; `rt_index`=0, `write_value`=0, `rsp_valid`=0, `rsp_data`=0, `req_ready`=0 while in reset.
- All reg_file-facing outputs are registered. Strobes are high for exactly one cycle, only in their state.
- `req_ready` = (state==IDLE). Handshake on `req_valid & req_ready` at posedge; command fields are captured then. Inputs are ignored while not ready.
- States: IDLE, RD, SD, WR, SS, RSP.
- Transitions and outputs per op (cycle 0 = accept edge):
  - WRITE: IDLE->SD->WR->RSP.
    - SD: `SETDEST`=1, `rt_index`=dst.
    - WR: `REGWRITE`=1, `write_value`=data.
    - `rsp_data`=data. `rsp_valid` first high in cycle 3.
  - READ: IDLE->RD->RSP.
    - RD: `rt_index`=src, strobes 0.
    - `rt` is sampled at the end of RD into `rsp_data`. `rsp_valid` in cycle 2.
  - COPY: IDLE->RD->SD->WR->RSP.
    - `rt` is captured at the end of RD; WR drives `write_value`=captured.
    - `rsp_data`=captured. `rsp_valid` in cycle 4.
  - SETSRC: IDLE->SS->RSP.
    - SS: `SETSRC`=1, `rt_index`=src.
    - `rsp_data`=0. `rsp_valid` in cycle 2.
- RSP: `rsp_valid`=1 and `rsp_data` stable until `rsp_ready`; then IDLE. `rsp_ready` back-pressure holds RSP indefinitely.
- Outside their driving states, `rt_index` and `write_value` hold their last driven value.
- COPY with src==dst: the full sequence still runs; the register value is unchanged.
- Back-to-back: accept is possible no earlier than the cycle after the RSP handshake, so the minimum command spacing is (latency+1) cycles.
- Reset mid-sequence: immediate return to IDLE, strobes drop asynchronously, and the pending command is lost with no response. A partially set dest pointer in reg_file is not undone.
- Illegal encodings: none (all 4 ops defined).

Decomposition:
- Package `reg_file_pkg`:
  - `op_e` enum: WRITE, READ, COPY, SETSRC.
  - `state_e` enum.
  - Constants REG_DW=8, REG_AW=3, NUM_REGS=8.
- No sub-module: a single FSM plus capture registers.
- The bench instantiates `reg_file_ctrl` + `reg_file` back-to-back.

Test Plan:
- WRITE dst=5 data=26 -> `SETDEST` high cycle 1 with `rt_index`=5; `REGWRITE` high cycle 2 with `write_value`=26; `rsp_valid` cycle 3, `rsp_data`=26; reg_file reg[5]==26.
- After that, READ src=5 -> cycle 1 `rt_index`=5 with no strobes; `rsp_valid` cycle 2, `rsp_data`=26.
- WRITE r2=8'hA5, then COPY src=2 dst=7 -> `rsp_data`=8'hA5 at cycle 4; READ 7 returns 8'hA5; reg[2] still 8'hA5.
- SETSRC src=6 after writing r6=8'h3C -> `SETSRC` single-cycle pulse with `rt_index`=6; `rs`==8'h3C from cycle 2; `rsp_data`=0.
- Hold `rsp_ready`=0 for 5 cycles after a READ -> `rsp_valid`/`rsp_data` stable and `req_ready`=0 throughout; a new `req_valid` is not accepted until one cycle after `rsp_ready`=1.
- Assert `RST_N`=0 during COPY's SD cycle -> strobes 0 immediately, no `REGWRITE` occurs, `rsp_valid` never rises, `req_ready`=1 one cycle after deassertion.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and constants for the register-file controller slice.
//   op_e    : command encodings carried on req_op
//   state_e : controller sequencing states
package reg_file_pkg;

    localparam int unsigned REG_DW   = 8;
    localparam int unsigned REG_AW   = 3;
    localparam int unsigned NUM_REGS = 8;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_READ   = 2'b01,
        OP_COPY   = 2'b10,
        OP_SETSRC = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_SD   = 3'd2,
        ST_WR   = 3'd3,
        ST_SS   = 3'd4,
        ST_RSP  = 3'd5
    } state_e;

endpackage

// File: rtl/reg_file.sv
// 8 x 8 register file driven by reg_file_ctrl.
//   SETSRC/SETDEST latch rt_index as source/destination pointer on CLK rise.
//   REGWRITE writes write_value to reg[dest] on CLK rise.
//   rt = reg[rt_index] (combinational), rs = reg[src].
// The storage has no reset; contents are only defined once written.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned DW = REG_DW,
    parameter int unsigned AW = REG_AW
) (
    input  logic          CLK,
    input  logic          SETSRC,
    input  logic          SETDEST,
    input  logic          REGWRITE,
    input  logic [AW-1:0] rt_index,
    input  logic [DW-1:0] write_value,
    output logic [DW-1:0] rs,
    output logic [DW-1:0] rt
);

    localparam int unsigned Depth = 1 << AW;

    logic [DW-1:0] regs [Depth];
    logic [AW-1:0] src_q;
    logic [AW-1:0] dst_q;

    always_ff @(posedge CLK) begin
        if (SETSRC)   src_q       <= rt_index;
        if (SETDEST)  dst_q       <= rt_index;
        if (REGWRITE) regs[dst_q] <= write_value;
    end

    assign rt = regs[rt_index];
    assign rs = regs[src_q];

endmodule

// File: rtl/reg_file_ctrl.sv
// Sequencer that turns single-beat register commands into reg_file strobe
// sequences and returns a single-beat response.
//   CLK, RST_N                        : clock, async active-low reset
//   req_valid/req_ready/req_*         : command channel (op, src, dst, data)
//   rsp_valid/rsp_ready/rsp_data      : response channel
//   SETSRC/SETDEST/REGWRITE/rt_index/
//   write_value                       : registered drive to reg_file
//   rs, rt                            : read data from reg_file
module reg_file_ctrl
    import reg_file_pkg::*;
#(
    parameter int unsigned DW = REG_DW,
    parameter int unsigned AW = REG_AW
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [AW-1:0] req_src,
    input  logic [AW-1:0] req_dst,
    input  logic [DW-1:0] req_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          SETSRC,
    output logic          SETDEST,
    output logic          REGWRITE,
    output logic [AW-1:0] rt_index,
    output logic [DW-1:0] write_value,
    input  logic [DW-1:0] rs,
    input  logic [DW-1:0] rt
);

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [DW-1:0] data_q, data_d;          // WRITE payload or COPY-captured rt
    logic          ready_q, ready_d;
    logic          setsrc_q, setsrc_d;
    logic          setdest_q, setdest_d;
    logic          regwrite_q, regwrite_d;
    logic [AW-1:0] rt_index_q, rt_index_d;
    logic [DW-1:0] write_value_q, write_value_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;

    // The source-pointer read port is observed by consumers downstream, not here.
    logic unused_rs;
    assign unused_rs = ^rs;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        dst_d         = dst_q;
        data_d        = data_q;
        setsrc_d      = 1'b0;
        setdest_d     = 1'b0;
        regwrite_d    = 1'b0;
        rt_index_d    = rt_index_q;
        write_value_d = write_value_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    op_d   = op_e'(req_op);
                    dst_d  = req_dst;
                    data_d = req_data;
                    unique case (op_e'(req_op))
                        OP_WRITE: begin
                            state_d    = ST_SD;
                            setdest_d  = 1'b1;
                            rt_index_d = req_dst;
                        end
                        OP_READ, OP_COPY: begin
                            state_d    = ST_RD;
                            rt_index_d = req_src;
                        end
                        OP_SETSRC: begin
                            state_d    = ST_SS;
                            setsrc_d   = 1'b1;
                            rt_index_d = req_src;
                        end
                    endcase
                end
            end
            ST_RD: begin
                // rt reflects reg[src] for the whole RD cycle; sample it on exit.
                if (op_q == OP_COPY) begin
                    data_d     = rt;
                    state_d    = ST_SD;
                    setdest_d  = 1'b1;
                    rt_index_d = dst_q;
                end else begin
                    rsp_data_d  = rt;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_SD: begin
                state_d       = ST_WR;
                regwrite_d    = 1'b1;
                write_value_d = data_q;
            end
            ST_WR: begin
                state_d     = ST_RSP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = data_q;
            end
            ST_SS: begin
                state_d     = ST_RSP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered ready keeps req_ready low during reset and the first cycle after it.
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_WRITE;
            dst_q         <= '0;
            data_q        <= '0;
            ready_q       <= 1'b0;
            setsrc_q      <= 1'b0;
            setdest_q     <= 1'b0;
            regwrite_q    <= 1'b0;
            rt_index_q    <= '0;
            write_value_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            dst_q         <= dst_d;
            data_q        <= data_d;
            ready_q       <= ready_d;
            setsrc_q      <= setsrc_d;
            setdest_q     <= setdest_d;
            regwrite_q    <= regwrite_d;
            rt_index_q    <= rt_index_d;
            write_value_q <= write_value_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

    assign req_ready   = ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign SETSRC      = setsrc_q;
    assign SETDEST     = setdest_q;
    assign REGWRITE    = regwrite_q;
    assign rt_index    = rt_index_q;
    assign write_value = write_value_q;

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Directed bench: reg_file_ctrl driving reg_file back-to-back.
module tb_reg_file_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [AW-1:0] req_src;
    logic [AW-1:0] req_dst;
    logic [DW-1:0] req_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          SETSRC;
    logic          SETDEST;
    logic          REGWRITE;
    logic [AW-1:0] rt_index;
    logic [DW-1:0] write_value;
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    reg_file_ctrl #(.DW(DW), .AW(AW)) u_dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_src    (req_src),
        .req_dst    (req_dst),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .SETSRC     (SETSRC),
        .SETDEST    (SETDEST),
        .REGWRITE   (REGWRITE),
        .rt_index   (rt_index),
        .write_value(write_value),
        .rs         (rs),
        .rt         (rt)
    );

    reg_file #(.DW(DW), .AW(AW)) u_rf (
        .CLK        (CLK),
        .SETSRC     (SETSRC),
        .SETDEST    (SETDEST),
        .REGWRITE   (REGWRITE),
        .rt_index   (rt_index),
        .write_value(write_value),
        .rs         (rs),
        .rt         (rt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command at a negedge; it is accepted at the following posedge.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] src,
                         input logic [AW-1:0] dst, input logic [DW-1:0] data);
        @(negedge CLK);
        req_valid = 1'b1;
        req_op    = op;
        req_src   = src;
        req_dst   = dst;
        req_data  = data;
        check("issue_ready", req_ready, 1);
        @(posedge CLK);
        #1 req_valid = 1'b0;
    endtask

    // Bounded wait for the response (rsp_ready assumed high), then let it handshake.
    task automatic wait_rsp(input string tag, input logic [DW-1:0] exp);
        int k = 0;
        @(negedge CLK);
        while (!rsp_valid && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_data"}, rsp_data, exp);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_src   = '0;
        req_dst   = '0;
        req_data  = '0;
        rsp_ready = 1'b1;

        // Reset state
        #2;
        check("rst_ready", req_ready, 0);
        check("rst_strobes", {SETSRC, SETDEST, REGWRITE}, 0);
        check("rst_rt_index", rt_index, 0);
        check("rst_write_value", write_value, 0);
        check("rst_rsp", {rsp_valid, rsp_data}, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        check("post_rst_ready_lo", req_ready, 0);
        @(negedge CLK);
        check("post_rst_ready_hi", req_ready, 1);

        // WRITE r5 = 26
        issue(2'b00, 3'd0, 3'd5, 8'd26);
        @(negedge CLK);
        check("wr_c1_setdest", SETDEST, 1);
        check("wr_c1_rt_index", rt_index, 5);
        check("wr_c1_regwrite", REGWRITE, 0);
        @(negedge CLK);
        check("wr_c2_regwrite", REGWRITE, 1);
        check("wr_c2_setdest", SETDEST, 0);
        check("wr_c2_write_value", write_value, 26);
        check("wr_c2_rsp_valid", rsp_valid, 0);
        @(negedge CLK);
        check("wr_c3_rsp_valid", rsp_valid, 1);
        check("wr_c3_rsp_data", rsp_data, 26);
        check("wr_reg5", u_rf.regs[5], 26);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("wr_done_valid", rsp_valid, 0);
        check("wr_done_ready", req_ready, 1);

        // READ r5
        issue(2'b01, 3'd5, 3'd0, 8'd0);
        @(negedge CLK);
        check("rd_c1_rt_index", rt_index, 5);
        check("rd_c1_strobes", {SETSRC, SETDEST, REGWRITE}, 0);
        check("rd_c1_rsp_valid", rsp_valid, 0);
        @(negedge CLK);
        check("rd_c2_rsp_valid", rsp_valid, 1);
        check("rd_c2_rsp_data", rsp_data, 26);
        @(posedge CLK);
        #1;

        // WRITE r2 = A5, COPY r2 -> r7
        issue(2'b00, 3'd0, 3'd2, 8'hA5);
        wait_rsp("wr_r2", 8'hA5);
        issue(2'b10, 3'd2, 3'd7, 8'h00);
        @(negedge CLK);
        check("cp_c1_rt_index", rt_index, 2);
        @(negedge CLK);
        check("cp_c2_setdest", SETDEST, 1);
        check("cp_c2_rt_index", rt_index, 7);
        @(negedge CLK);
        check("cp_c3_regwrite", REGWRITE, 1);
        check("cp_c3_write_value", write_value, 8'hA5);
        check("cp_c3_rsp_valid", rsp_valid, 0);
        @(negedge CLK);
        check("cp_c4_rsp_valid", rsp_valid, 1);
        check("cp_c4_rsp_data", rsp_data, 8'hA5);
        @(posedge CLK);
        #1;
        issue(2'b01, 3'd7, 3'd0, 8'd0);
        wait_rsp("rd_r7", 8'hA5);
        issue(2'b01, 3'd2, 3'd0, 8'd0);
        wait_rsp("rd_r2", 8'hA5);

        // WRITE r6 = 3C, SETSRC 6
        issue(2'b00, 3'd0, 3'd6, 8'h3C);
        wait_rsp("wr_r6", 8'h3C);
        issue(2'b11, 3'd6, 3'd0, 8'hFF);
        @(negedge CLK);
        check("ss_c1_setsrc", SETSRC, 1);
        check("ss_c1_rt_index", rt_index, 6);
        check("ss_c1_other", {SETDEST, REGWRITE}, 0);
        @(negedge CLK);
        check("ss_c2_setsrc", SETSRC, 0);
        check("ss_c2_rsp_valid", rsp_valid, 1);
        check("ss_c2_rsp_data", rsp_data, 0);
        check("ss_c2_rs", rs, 8'h3C);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("ss_c3_rs", rs, 8'h3C);

        // COPY with src == dst leaves the value unchanged
        issue(2'b10, 3'd6, 3'd6, 8'h00);
        wait_rsp("cp_same", 8'h3C);
        issue(2'b01, 3'd6, 3'd0, 8'd0);
        wait_rsp("rd_r6", 8'h3C);

        // Response back-pressure; a pending command must wait
        rsp_ready = 1'b0;
        issue(2'b01, 3'd5, 3'd0, 8'd0);
        @(negedge CLK);
        @(negedge CLK);
        check("bp_c2_valid", rsp_valid, 1);
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_src   = 3'd0;
        req_dst   = 3'd1;
        req_data  = 8'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_data", rsp_data, 26);
            check("bp_hold_ready", req_ready, 0);
            check("bp_hold_setdest", SETDEST, 0);
        end
        rsp_ready = 1'b1;
        @(negedge CLK);
        check("bp_release_valid", rsp_valid, 0);
        check("bp_release_ready", req_ready, 1);
        check("bp_release_setdest", SETDEST, 0);
        @(posedge CLK);
        #1 req_valid = 1'b0;
        @(negedge CLK);
        check("bp_accept_setdest", SETDEST, 1);
        check("bp_accept_rt_index", rt_index, 1);
        wait_rsp("bp_wr", 8'h77);

        // Reset during COPY's SD cycle (r5 -> r7)
        issue(2'b10, 3'd5, 3'd7, 8'h00);
        @(negedge CLK);
        @(negedge CLK);
        check("mr_sd_setdest", SETDEST, 1);
        #1 RST_N = 1'b0;
        #1;
        check("mr_strobes", {SETSRC, SETDEST, REGWRITE}, 0);
        check("mr_ready", req_ready, 0);
        check("mr_rsp_valid", rsp_valid, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        check("mr_deassert_ready", req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("mr_no_regwrite", REGWRITE, 0);
            check("mr_no_rsp", rsp_valid, 0);
            check("mr_ready_back", req_ready, 1);
        end
        issue(2'b01, 3'd7, 3'd0, 8'd0);
        wait_rsp("mr_rd_r7", 8'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
